fifo_rd_stream_adapter: RTL and testbench

- Read-domain consumer of the async FIFO. Pops the FIFO through its rd_en/data_out/empty interface and presents the words as a valid/ready stream with a 2-entry skid buffer.
- Absorbs the FIFO's 1-cycle registered read latency, so a downstream that accepts every cycle sees 1 word/cycle.
- Adds a synchronous flush that drops buffered and in-flight words.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/stream_skid_buf.sv | 84 ++++++++
 rtl/fifo_rd_stream_adapter.sv | 73 +++++++
 tb/tb_fifo_rd_stream_adapter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned OCC_WIDTH       = 2;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order skid storage: head register drives the stream, second
// register absorbs a word that arrives while the head is stalled.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  input  logic                  flush,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head,
  output logic [OCC_WIDTH-1:0]  count
);

  buf_state_e            state;
  buf_state_e            state_nxt;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic [DATA_WIDTH-1:0] second_q;
  logic [DATA_WIDTH-1:0] second_nxt;
  logic                  valid_q;

  // State and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BUF_EMPTY;
      head_q   <= '0;
      second_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      head_q   <= head_nxt;
      second_q <= second_nxt;
      valid_q  <= (state_nxt != BUF_EMPTY);
    end
  end

  // Next occupancy and entry movement; a pop with count=2 promotes second to head.
  always_comb begin
    state_nxt  = state;
    head_nxt   = head_q;
    second_nxt = second_q;
    if (flush) begin
      state_nxt = BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (capture) begin
            state_nxt = BUF_ONE;
            head_nxt  = wdata;
          end
        end
        BUF_ONE: begin
          case ({capture, pop})
            2'b11: head_nxt = wdata;
            2'b10: begin
              state_nxt  = BUF_TWO;
              second_nxt = wdata;
            end
            2'b01: state_nxt = BUF_EMPTY;
            default: ;
          endcase
        end
        BUF_TWO: begin
          if (pop) begin
            head_nxt = second_q;
            if (capture) second_nxt = wdata;
            else         state_nxt  = BUF_ONE;
          end
        end
        default: state_nxt = BUF_EMPTY;
      endcase
    end
  end

  assign valid = valid_q;
  assign head  = head_q;
  assign count = OCC_WIDTH'(state);

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Pops the async FIFO read side and presents words as a valid/ready stream
// through a 2-entry skid buffer, hiding the FIFO's 1-cycle read latency.
// Optional accepted-beat counter: define FIFO_RD_STREAM_ADAPTER_BEAT_CNT_EN.
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [OCC_WIDTH-1:0]  occupancy,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  localparam int unsigned SUM_W = OCC_WIDTH + 1;

  logic                 pend_q;
  logic                 pop;
  logic [OCC_WIDTH-1:0] count;
  logic [SUM_W-1:0]     inflight;

  assign pop      = m_valid && m_ready;
  assign inflight = SUM_W'(count) + SUM_W'(pend_q);

  // Issue a read only when the word is guaranteed a slot on arrival.
  assign fifo_rd_en = rst_n && !fifo_empty && !flush &&
                      ((inflight < SUM_W'(2)) || ((inflight == SUM_W'(2)) && pop));

  // Tracks the word in flight from the FIFO's registered output.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= fifo_rd_en;
  end

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (rd_clk),
    .rst_n   (rst_n),
    .capture (pend_q && !flush),
    .wdata   (fifo_data),
    .pop     (pop),
    .flush   (flush),
    .valid   (m_valid),
    .head    (m_data),
    .count   (count)
  );

  assign occupancy = count;

`ifdef FIFO_RD_STREAM_ADAPTER_BEAT_CNT_EN
  logic [CNT_WIDTH-1:0] beat_q;

  // Counts every completed transfer, including one made during a flush.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n)   beat_q <= '0;
    else if (pop) beat_q <= beat_q + CNT_WIDTH'(1);
  end

  assign beat_cnt = beat_q;
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a behavioural FIFO read side.
module tb_fifo_rd_stream_adapter;

  logic        rd_clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_en;
  logic        flush;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic [1:0]  occupancy;
  logic [15:0] beat_cnt;
  logic        empty_gate;

  logic [7:0]  mem [0:255];
  logic [7:0]  rcv [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          rcv_cnt = 0;
  int          rd_viol = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          base_rd;
  int          base_rcv;
  logic [15:0] rpat;

  fifo_rd_stream_adapter dut (
    .rd_clk     (rd_clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .occupancy  (occupancy),
    .beat_cnt   (beat_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO read side: registered data_out, one word per rd_en.
  assign fifo_empty = (wr_ptr == rd_ptr) || empty_gate;

  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[8'(rd_ptr)];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Mid-cycle monitor: empty-rule violations and accepted beats.
  always @(negedge rd_clk) begin
    if (fifo_rd_en && fifo_empty) rd_viol = rd_viol + 1;
    if (rst_n && m_valid && m_ready) begin
      rcv[8'(rcv_cnt)] = m_data;
      rcv_cnt = rcv_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[8'(wr_ptr)] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_beat(input int n);
    int r;
    r = n;
`ifndef FIFO_RD_STREAM_ADAPTER_BEAT_CNT_EN
    r = 0;
`endif
    return 32'(r);
  endfunction

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    m_ready    = 1'b0;
    empty_gate = 1'b0;
    repeat (3) tick();

    // Reset state with a non-empty FIFO: no read may issue.
    for (int i = 0; i < 16; i++) push(8'(i + 1));
    settle();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_beat", 32'(beat_cnt), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);

    // Streaming: 16 words, full throughput after 2-cycle latency.
    m_ready = 1'b1;
    rst_n   = 1'b1;
    settle();
    chk("stream_rd_en_n", 32'(fifo_rd_en), 32'd1);
    chk("stream_valid_n", 32'(m_valid), 32'd0);
    tick();
    chk("stream_valid_n1", 32'(m_valid), 32'd0);
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("stream_valid", 32'(m_valid), 32'd1);
      chk("stream_data", 32'(m_data), 32'(k + 1));
      tick();
    end
    chk("stream_end_valid", 32'(m_valid), 32'd0);
    chk("stream_end_occ", 32'(occupancy), 32'd0);
    chk("stream_beat", 32'(beat_cnt), exp_beat(16));
    chk("stream_rcv_cnt", 32'(rcv_cnt), 32'd16);
    for (int i = 0; i < 16; i++) chk("stream_rcv", 32'(rcv[i]), 32'(i + 1));

    // Backpressure: only 2 pops, head held, then ordered drain.
    m_ready  = 1'b0;
    base_rd  = rd_ptr;
    base_rcv = rcv_cnt;
    for (int i = 0; i < 5; i++) push(8'(8'h21 + i));
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 1) begin
        chk("bp_hold_valid", 32'(m_valid), 32'd1);
        chk("bp_hold_data", 32'(m_data), 32'h21);
      end
    end
    chk("bp_pops", 32'(rd_ptr - base_rd), 32'd2);
    chk("bp_occ", 32'(occupancy), 32'd2);
    chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
    m_ready = 1'b1;
    repeat (12) tick();
    chk("bp_rcv_cnt", 32'(rcv_cnt - base_rcv), 32'd5);
    for (int i = 0; i < 5; i++) chk("bp_rcv", 32'(rcv[base_rcv + i]), 32'(8'h21 + i));
    chk("bp_beat", 32'(beat_cnt), exp_beat(21));
    chk("bp_end_valid", 32'(m_valid), 32'd0);

    // Empty flag toggling with an irregular ready pattern.
    base_rcv = rcv_cnt;
    rpat     = 16'hB2E5;
    for (int i = 0; i < 8; i++) push(8'(8'h31 + i));
    for (int c = 0; c < 40; c++) begin
      empty_gate = ((c % 2) == 1);
      m_ready    = rpat[4'(c % 16)];
      tick();
    end
    empty_gate = 1'b0;
    m_ready    = 1'b1;
    repeat (10) tick();
    chk("empty_viol", 32'(rd_viol), 32'd0);
    chk("empty_rcv_cnt", 32'(rcv_cnt - base_rcv), 32'd8);
    for (int i = 0; i < 8; i++) chk("empty_rcv", 32'(rcv[base_rcv + i]), 32'(8'h31 + i));
    chk("empty_beat", 32'(beat_cnt), exp_beat(29));

    // Flush with head buffered and a word in flight.
    m_ready  = 1'b0;
    base_rcv = rcv_cnt;
    push(8'h41);
    push(8'h42);
    push(8'h43);
    tick();
    tick();
    chk("fl_pre_valid", 32'(m_valid), 32'd1);
    chk("fl_pre_occ", 32'(occupancy), 32'd1);
    chk("fl_pre_data", 32'(m_data), 32'h41);
    flush = 1'b1;
    settle();
    chk("fl_rd_en", 32'(fifo_rd_en), 32'd0);
    tick();
    flush = 1'b0;
    settle();
    chk("fl_post_valid", 32'(m_valid), 32'd0);
    chk("fl_post_occ", 32'(occupancy), 32'd0);
    chk("fl_resume_rd_en", 32'(fifo_rd_en), 32'd1);
    tick();
    chk("fl_gap_valid", 32'(m_valid), 32'd0);
    tick();
    chk("fl_next_valid", 32'(m_valid), 32'd1);
    chk("fl_next_data", 32'(m_data), 32'h43);
    m_ready = 1'b1;
    repeat (4) tick();
    chk("fl_rcv_cnt", 32'(rcv_cnt - base_rcv), 32'd1);
    chk("fl_rcv", 32'(rcv[base_rcv]), 32'h43);
    chk("fl_beat", 32'(beat_cnt), exp_beat(30));

    // Flush coinciding with a pop, then back-to-back flush cycles.
    m_ready  = 1'b0;
    base_rcv = rcv_cnt;
    for (int i = 0; i < 4; i++) push(8'(8'h51 + i));
    repeat (3) tick();
    chk("flp_pre_occ", 32'(occupancy), 32'd2);
    chk("flp_pre_data", 32'(m_data), 32'h51);
    m_ready = 1'b1;
    flush   = 1'b1;
    settle();
    chk("flp_rd_en", 32'(fifo_rd_en), 32'd0);
    tick();
    m_ready = 1'b0;
    settle();
    chk("flp_valid", 32'(m_valid), 32'd0);
    chk("flp_occ", 32'(occupancy), 32'd0);
    chk("flp_beat", 32'(beat_cnt), exp_beat(31));
    chk("flp_rcv_cnt", 32'(rcv_cnt - base_rcv), 32'd1);
    chk("flp_rcv", 32'(rcv[base_rcv]), 32'h51);
    chk("flp_b2b_rd_en", 32'(fifo_rd_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flp_b2b_valid", 32'(m_valid), 32'd0);
      chk("flp_b2b_occ", 32'(occupancy), 32'd0);
      chk("flp_b2b_rd_en", 32'(fifo_rd_en), 32'd0);
    end
    flush   = 1'b0;
    m_ready = 1'b1;
    repeat (6) tick();
    chk("flp_drain_cnt", 32'(rcv_cnt - base_rcv), 32'd3);
    chk("flp_drain_0", 32'(rcv[base_rcv + 1]), 32'h53);
    chk("flp_drain_1", 32'(rcv[base_rcv + 2]), 32'h54);
    chk("flp_drain_beat", 32'(beat_cnt), exp_beat(33));

    // Asynchronous reset while full and a read is being issued.
    m_ready  = 1'b0;
    base_rcv = rcv_cnt;
    push(8'h61);
    push(8'h62);
    push(8'h63);
    repeat (3) tick();
    m_ready = 1'b1;
    settle();
    chk("ar_pre_rd_en", 32'(fifo_rd_en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("ar_valid", 32'(m_valid), 32'd0);
    chk("ar_occ", 32'(occupancy), 32'd0);
    chk("ar_beat", 32'(beat_cnt), 32'd0);
    chk("ar_data", 32'(m_data), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("ar_rel_valid", 32'(m_valid), 32'd0);
    repeat (6) tick();
    chk("ar_rcv_cnt", 32'(rcv_cnt - base_rcv), 32'd1);
    chk("ar_rcv", 32'(rcv[base_rcv]), 32'h63);
    chk("ar_beat_after", 32'(beat_cnt), exp_beat(1));
    chk("ar_end_valid", 32'(m_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
